ipg_wreq_tx: RTL and testbench
==============================

// Module: ipg_wreq_tx
// PURPOSE
//  Transmit side of the IPG write-request channel. Accepts one write request (12-bit address,
//  up to 512 payload bits) and serialises it into inter-packet-gap slots offered by the PHY:
//  one header chunk, then payload chunks sized to each slot.
//  Sits between the memory-request issuer and the PHY IPG insertion path; the peer is the IPG write-request receiver.
// PARAMETERS
//  DATA_WIDTH   64   IPG chunk width, bits
//  HDR_WIDTH    16   header length field; carries payload length in bits
//  ADR_WIDTH    12   write address width
//  PAYLOAD_LEN  512  max payload bits per request
//  CNT_WIDTH    10   remaining-bit counter width; must hold PAYLOAD_LEN
// PORTS
//  clk            in   1            clock
//  reset          in   1            asynchronous, active-high reset
//  req_valid      in   1            write request present
//  req_ready      out  1            high in IDLE only; request taken when req_valid & req_ready
//  req_addr       in   ADR_WIDTH    target address
//  req_len        in   CNT_WIDTH    payload length in bits; legal range 1..PAYLOAD_LEN
//  req_payload    in   PAYLOAD_LEN  payload; bits [req_len-1:0] valid, sent MSB first
//  slot_valid     in   1            PHY offers an IPG slot this cycle
//  slot_len       in   6            usable bits in the offered slot, 0..63
//  tx_ipg_data    out  DATA_WIDTH   chunk, left-justified (bit 63 first)
//  tx_len         out  6            valid bits in tx_ipg_data
//  wreq_valid     out  1            chunk valid; one-cycle pulse per chunk
//  busy           out  1            request in flight (state != IDLE)
//  drop_err       out  1            one-cycle pulse: illegal req_len accepted and discarded
// BEHAVIOUR
//  Reset: state=IDLE; tx_ipg_data=0, tx_len=0, wreq_valid=0, busy=0, drop_err=0, req_ready=1. Internal regs cleared.
//  All outputs except req_ready are registered. req_ready = (state==IDLE).
//  IDLE: on req_valid & req_ready:
//   - req_len==0 or req_len>PAYLOAD_LEN: pulse drop_err next cycle, stay IDLE.
//   - otherwise latch addr, payload and rem=req_len, then go to HDR.
//  HDR: on a slot with slot_valid & slot_len>=28, emit header at the next edge:
//   - tx_ipg_data[63:48]=zero-extended rem; [47:36]=addr; [35:0]=0.
//   - tx_len=28, wreq_valid=1; go to DATA.
//   - A slot with slot_len<28 is skipped; the header is never split.
//  DATA: on slot_valid & slot_len>0:
//   - n=min(slot_len,rem).
//   - tx_ipg_data[63 -: n]=payload[rem-1 -: n]; remaining bits 0.
//   - tx_len=n, wreq_valid=1, rem<=rem-n.
//   - When rem reaches 0, go to IDLE; a new request can be accepted the cycle after the last chunk.
//  Latency: slot offered in cycle N -> chunk visible in cycle N+1. No slot -> wreq_valid=0; tx_ipg_data/tx_len hold.
//  Nothing is emitted in the request-accept cycle. At least 1 header cycle + ceil(len/63) data cycles.
//  slot_len=0 with slot_valid=1 is treated as no slot.
//  Arithmetic: rem is CNT_WIDTH unsigned; the min() compare uses zero-extended slot_len; no underflow is possible.
//  Reset mid-request: abort immediately, drop the partial request, outputs return to reset values.
// STRUCTURE
//  Shared package ipg_pkg:
//   - DATA_WIDTH, HDR_WIDTH, ADR_WIDTH, PAYLOAD_LEN, CNT_WIDTH, IPG_HDR_BITS=28.
//   - State encoding IDLE/HDR/DATA, shared with the receiver.
//  Sub-module ipg_chunk_sel: combinational; takes payload, rem, n; returns the left-justified 64-bit chunk.
//  The FSM, counter and output regs stay in ipg_wreq_tx.
// TESTING
//  1 addr=0xABC, len=40, payload[39:0]=0xF0_1234_5678, slot_len=63 every cycle:
//    -> header 0x0028_ABC0_0000_0000 (tx_len 28)
//    -> then one chunk with data[63:24]=0xF012345678, tx_len 40, then IDLE.
//  2 len=130, slot_len=63 constant -> header, then chunks of tx_len 63, 63, 4; rem 67->4->0; total bits match payload.
//  3 len=20, slot_len sequence 10, 27, 30, 5, 50 -> no output for 10 or 27; header on 30; chunks tx_len 5 then 15.
//  4 slot_valid low 5 cycles mid-DATA -> wreq_valid stays 0; data resumes without loss; busy held high.
//  5 req_len=0, then req_len=513 -> drop_err pulse for each; no wreq_valid; req_ready stays 1.
//  6 reset asserted mid-DATA (len=512) -> outputs zero immediately; next request starts with a header; loopback to the receiver shows an exact payload match.

Source files
------------

// File: rtl/ipg_pkg.sv
// ipg_pkg: shared IPG write-request parameters and state encoding
package ipg_pkg;
    localparam int DATA_WIDTH   = 64;
    localparam int HDR_WIDTH    = 16;
    localparam int ADR_WIDTH    = 12;
    localparam int PAYLOAD_LEN  = 512;
    localparam int CNT_WIDTH    = 10;
    localparam int IPG_HDR_BITS = 28;
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2} ipg_state_e;
endpackage

// File: rtl/ipg_chunk_sel.sv
// ipg_chunk_sel: pick payload[rem-1 -: n] and left-justify it in a 64-bit chunk
module ipg_chunk_sel
    import ipg_pkg::*;
(
    input  logic [PAYLOAD_LEN-1:0] payload,
    input  logic [CNT_WIDTH-1:0]   rem,
    input  logic [5:0]             n,
    output logic [DATA_WIDTH-1:0]  chunk
);
    logic [CNT_WIDTH-1:0]   sh;
    logic [PAYLOAD_LEN-1:0] aligned;
    logic [DATA_WIDTH-1:0]  mask;
    // shifting bit rem-1 to the top also pushes out any stale bits above the length
    assign sh      = CNT_WIDTH'(PAYLOAD_LEN) - rem;
    assign aligned = payload << sh;
    assign mask    = ~({DATA_WIDTH{1'b1}} >> n);
    assign chunk   = aligned[PAYLOAD_LEN-1 -: DATA_WIDTH] & mask;
endmodule

// File: rtl/ipg_wreq_tx.sv
// ipg_wreq_tx: serialise one write request into PHY inter-packet-gap slots
module ipg_wreq_tx
    import ipg_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADR_WIDTH-1:0]   req_addr,
    input  logic [CNT_WIDTH-1:0]   req_len,
    input  logic [PAYLOAD_LEN-1:0] req_payload,
    input  logic                   slot_valid,
    input  logic [5:0]             slot_len,
    output logic [DATA_WIDTH-1:0]  tx_ipg_data,
    output logic [5:0]             tx_len,
    output logic                   wreq_valid,
    output logic                   busy,
    output logic                   drop_err
);
    ipg_state_e             state, state_d;
    logic [ADR_WIDTH-1:0]   addr_q;
    logic [PAYLOAD_LEN-1:0] pay_q;
    logic [CNT_WIDTH-1:0]   rem_q;
    logic                   take, len_ok, slot_ok, hdr_go, dat_go;
    logic [5:0]             n;
    logic [DATA_WIDTH-1:0]  chunk, hdr_word;

    assign req_ready = (state == IDLE);
    assign hdr_word  = {HDR_WIDTH'(rem_q), addr_q, {(DATA_WIDTH-HDR_WIDTH-ADR_WIDTH){1'b0}}};

    ipg_chunk_sel u_sel (.payload(pay_q), .rem(rem_q), .n(n), .chunk(chunk));

    // next-state and slot qualification; a zero-length slot counts as no slot
    always_comb begin
        take    = req_valid && req_ready;
        len_ok  = (req_len != '0) && (req_len <= CNT_WIDTH'(PAYLOAD_LEN));
        slot_ok = slot_valid && (slot_len != '0);
        n       = (CNT_WIDTH'(slot_len) < rem_q) ? slot_len : rem_q[5:0];
        hdr_go  = (state == HDR) && slot_ok && (slot_len >= 6'(IPG_HDR_BITS));
        dat_go  = (state == DATA) && slot_ok;
        state_d = state;
        case (state)
            IDLE:    if (take && len_ok) state_d = HDR;
            HDR:     if (hdr_go) state_d = DATA;
            DATA:    if (dat_go && CNT_WIDTH'(n) == rem_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // request latch, remaining-bit counter and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            pay_q       <= '0;
            rem_q       <= '0;
            tx_ipg_data <= '0;
            tx_len      <= '0;
            wreq_valid  <= 1'b0;
            busy        <= 1'b0;
            drop_err    <= 1'b0;
        end else begin
            wreq_valid <= hdr_go || dat_go;
            drop_err   <= take && !len_ok;
            busy       <= (state_d != IDLE);
            if (take && len_ok) begin
                addr_q <= req_addr;
                pay_q  <= req_payload;
                rem_q  <= req_len;
            end
            if (hdr_go) begin
                tx_ipg_data <= hdr_word;
                tx_len      <= 6'(IPG_HDR_BITS);
            end
            if (dat_go) begin
                tx_ipg_data <= chunk;
                tx_len      <= n;
                rem_q       <= rem_q - CNT_WIDTH'(n);
            end
        end
    end
endmodule

// File: tb/tb_ipg_wreq_tx.sv
// tb_ipg_wreq_tx: scoreboard bench for the IPG write-request transmitter
module tb_ipg_wreq_tx;
    import ipg_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_ready, slot_valid, wreq_valid, busy, drop_err;
    logic [11:0]  req_addr;
    logic [9:0]   req_len;
    logic [511:0] req_payload;
    logic [5:0]   slot_len, tx_len;
    logic [63:0]  tx_ipg_data;

    typedef struct {logic [63:0] d; logic [5:0] l; bit is_data;} chunk_t;
    chunk_t       sb[$];
    int           lens[$];
    int           n_chk = 0, n_fail = 0;
    int           m_state = 0;
    logic [9:0]   m_rem;
    logic [11:0]  m_addr;
    logic [511:0] m_pay, acc, pay;
    logic [63:0]  last_d;

    ipg_wreq_tx dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .req_payload(req_payload),
        .slot_valid(slot_valid), .slot_len(slot_len), .tx_ipg_data(tx_ipg_data),
        .tx_len(tx_len), .wreq_valid(wreq_valid), .busy(busy), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] len_mask(input int len);
        return (512'(1) << len) - 512'(1);
    endfunction

    task automatic cyc(input bit rv, input logic [9:0] rl, input logic [11:0] ra,
                       input logic [511:0] rp, input bit sv, input logic [5:0] sl);
        bit     ev = 0, ed = 0;
        chunk_t c;
        int     n;
        req_valid = rv; req_len = rl; req_addr = ra; req_payload = rp;
        slot_valid = sv; slot_len = sl;
        check("req_ready", req_ready, m_state == 0);
        case (m_state)
            0: if (rv) begin
                if (rl == 0 || rl > 512) ed = 1;
                else begin m_addr = ra; m_pay = rp; m_rem = rl; m_state = 1; end
            end
            1: if (sv && sl >= 28) begin
                c.d = {6'b0, m_rem, m_addr, 36'b0}; c.l = 28; c.is_data = 0;
                sb.push_back(c); ev = 1; m_state = 2;
            end
            2: if (sv && sl != 0) begin
                n = (sl < m_rem) ? int'(sl) : int'(m_rem);
                c.d = '0;
                for (int i = 0; i < n; i++) c.d[63-i] = m_pay[int'(m_rem)-1-i];
                c.l = 6'(n); c.is_data = 1;
                sb.push_back(c); ev = 1;
                m_rem = m_rem - 10'(n);
                if (m_rem == 0) m_state = 0;
            end
            default: m_state = 0;
        endcase
        @(posedge clk); #1;
        check("wreq_valid", wreq_valid, ev);
        check("drop_err", drop_err, ed);
        check("busy", busy, m_state != 0);
        if (wreq_valid) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                c = sb.pop_front();
                check("tx_ipg_data", tx_ipg_data, c.d);
                check("tx_len", tx_len, c.l);
                if (c.is_data) acc = (acc << tx_len) | 512'(tx_ipg_data >> (64 - int'(tx_len)));
            end
            lens.push_back(int'(tx_len));
            last_d = tx_ipg_data;
        end
        req_valid = 0;
    endtask

    task automatic run(input logic [5:0] sl);
        for (int i = 0; i < 100 && m_state != 0; i++) cyc(0, 0, 0, 0, 1, sl);
        check("run_done", m_state, 0);
    endtask

    task automatic check_lens(input string tag, input int exp[$]);
        check({tag, "_count"}, lens.size(), exp.size());
        for (int i = 0; i < exp.size() && i < lens.size(); i++) check(tag, lens[i], exp[i]);
    endtask

    task automatic start(input logic [9:0] len, input logic [11:0] addr, input logic [511:0] p);
        lens.delete(); acc = '0;
        cyc(1, len, addr, p, 1, 63);
    endtask

    initial begin
        reset = 1; req_valid = 0; req_len = 0; req_addr = 0; req_payload = 0;
        slot_valid = 0; slot_len = 0; acc = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", tx_ipg_data, 0);
        check("rst_len", tx_len, 0);
        check("rst_valid", wreq_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_err, 0);
        check("rst_ready", req_ready, 1);
        reset = 0;
        @(posedge clk); #1;

        // 1: single 40-bit request, generous slots
        pay = '0; pay[39:0] = 40'hF0_1234_5678;
        start(40, 12'hABC, pay);
        cyc(0, 0, 0, 0, 1, 63);
        check("t1_hdr", last_d, 64'h0028_ABC0_0000_0000);
        check("t1_hdr_len", tx_len, 28);
        cyc(0, 0, 0, 0, 1, 63);
        check("t1_data", last_d, 64'hF012_3456_7800_0000);
        check("t1_data_len", tx_len, 40);
        check("t1_idle", req_ready, 1);

        // 2: 130 bits over 63-bit slots
        pay = rnd512();
        start(130, 12'h123, pay);
        run(63);
        check_lens("t2_lens", '{28, 63, 63, 4});
        check("t2_payload", acc, pay & len_mask(130));

        // 3: undersized slots are skipped, header never split
        pay = rnd512();
        start(20, 12'h5A5, pay);
        cyc(0, 0, 0, 0, 1, 10);
        cyc(0, 0, 0, 0, 1, 27);
        cyc(0, 0, 0, 0, 1, 30);
        cyc(0, 0, 0, 0, 1, 5);
        cyc(0, 0, 0, 0, 1, 50);
        check_lens("t3_lens", '{28, 5, 15});
        check("t3_payload", acc, pay & len_mask(20));
        check("t3_idle", req_ready, 1);

        // 4: slot gap mid-DATA, then a zero-length slot
        pay = rnd512();
        start(200, 12'h0F0, pay);
        cyc(0, 0, 0, 0, 1, 63);
        cyc(0, 0, 0, 0, 1, 63);
        repeat (5) cyc(0, 0, 0, 0, 0, 63);
        check("t4_hold_len", tx_len, 63);
        cyc(0, 0, 0, 0, 1, 0);
        run(37);
        check("t4_payload", acc, pay & len_mask(200));

        // 5: illegal lengths are dropped
        lens.delete();
        cyc(1, 0, 12'h111, rnd512(), 1, 63);
        cyc(1, 513, 12'h222, rnd512(), 1, 63);
        cyc(0, 0, 0, 0, 1, 63);
        check("t5_no_chunks", lens.size(), 0);

        // 6: reset mid-DATA, then a full 512-bit request
        pay = rnd512();
        start(512, 12'hFFF, pay);
        repeat (4) cyc(0, 0, 0, 0, 1, 63);
        reset = 1;
        #1;
        check("t6_rst_data", tx_ipg_data, 0);
        check("t6_rst_len", tx_len, 0);
        check("t6_rst_valid", wreq_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", req_ready, 1);
        m_state = 0; sb.delete();
        @(posedge clk); #2;
        reset = 0;
        @(negedge clk);
        @(posedge clk); #1;
        pay = rnd512();
        start(512, 12'h3C3, pay);
        cyc(0, 0, 0, 0, 1, 63);
        check("t6_hdr", last_d, {16'd512, 12'h3C3, 36'b0});
        run(63);
        check("t6_payload", acc, pay);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
